bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 24 ++
 rtl/bus_arbiter_watchdog.sv | 32 +++
 rtl/bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_bus_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master serial bus arbiter:
// arbiter state encoding, master index type and grant helper.
package bus_pkg;

   localparam int NUM_MASTERS = 2;
   localparam int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef logic [IDX_W-1:0] master_idx_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_TURN = 2'd2
   } arb_state_e;

   // One-hot vector with the bit of the given master set.
   function automatic logic [NUM_MASTERS-1:0] f_onehot(input master_idx_t idx);
      logic [NUM_MASTERS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// Ownership watchdog: counts cycles the current owner has held the bus
// and flags when the hold limit is reached.
module arb_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int                CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;

   // Clear on a new grant, otherwise count owned cycles and stick at the limit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && (r_cnt != LIMIT)) begin
         r_cnt <= r_cnt + ONE;
      end
   end

   assign o_expire = (r_cnt == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared serial bus. The owner's
// master-side signals are routed to the bus and the bus responses are
// routed back to the owner only; everyone else sees zeros.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NUM_MASTERS-1:0] m_req,
   output logic [NUM_MASTERS-1:0] m_grant,
   input  logic [NUM_MASTERS-1:0] m_mode,
   input  logic [NUM_MASTERS-1:0] m_wr_bus,
   input  logic [NUM_MASTERS-1:0] m_mvalid,
   input  logic [NUM_MASTERS-1:0] m_mready,
   output logic [NUM_MASTERS-1:0] m_rd_bus,
   output logic [NUM_MASTERS-1:0] m_sready,
   output logic [NUM_MASTERS-1:0] m_svalid,
   output logic                   bus_mode,
   output logic                   bus_wr,
   output logic                   bus_mvalid,
   output logic                   bus_mready,
   input  logic                   bus_rd,
   input  logic                   bus_sready,
   input  logic                   bus_svalid,
   output logic                   busy,
   output logic                   owner,
   output logic                   timeout_err
);

   arb_state_e  r_state;
   arb_state_e  w_state_nxt;
   master_idx_t r_owner;
   master_idx_t w_owner_nxt;
   logic        r_armed;
   logic        r_timeout_err;
   logic        w_timeout_nxt;
   logic        w_start;
   logic        w_expire;
   logic        w_busy;
   logic [NUM_MASTERS-1:0] w_owner_vec;

   arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rstn     (rstn),
      .i_clear  (w_start),
      .i_enable (w_busy),
      .o_expire (w_expire)
   );

   // Next-state, next-owner and forced-release decision.
   always_comb begin
      w_state_nxt   = r_state;
      w_owner_nxt   = r_owner;
      w_timeout_nxt = 1'b0;
      w_start       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // r_armed holds off arbitration for the first edge after reset.
            if (r_armed && (|m_req)) begin
               w_state_nxt = ST_BUSY;
               w_start     = 1'b1;
               if (&m_req) begin
                  // Tie: the master that did not own the bus last wins.
                  w_owner_nxt = ~r_owner;
               end else begin
                  w_owner_nxt = m_req[1] ? master_idx_t'(1) : master_idx_t'(0);
               end
            end
         end
         ST_BUSY: begin
            // A voluntary release wins over the watchdog in the same cycle.
            if (!m_req[r_owner]) begin
               w_state_nxt = ST_TURN;
            end else if (w_expire) begin
               w_state_nxt   = ST_TURN;
               w_timeout_nxt = 1'b1;
            end
         end
         ST_TURN: begin
            // r_owner is left untouched, so it becomes the last owner for round-robin.
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register; reset returns straight to IDLE with no TURN cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Owner register; resets to 1 so master 0 wins the first tie.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_owner <= master_idx_t'(1);
      end else begin
         r_owner <= w_owner_nxt;
      end
   end

   // Forced-release pulse, high only during the TURN cycle it caused.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_timeout_nxt;
      end
   end

   // Arm flag set by the first edge after reset release.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_armed <= 1'b0;
      end else begin
         r_armed <= 1'b1;
      end
   end

   assign w_busy      = (r_state == ST_BUSY);
   assign w_owner_vec = f_onehot(r_owner);

   assign m_grant     = w_busy ? w_owner_vec : '0;

   assign bus_mode    = w_busy & m_mode[r_owner];
   assign bus_wr      = w_busy & m_wr_bus[r_owner];
   assign bus_mvalid  = w_busy & m_mvalid[r_owner];
   assign bus_mready  = w_busy & m_mready[r_owner];

   assign m_rd_bus    = (w_busy & bus_rd)     ? w_owner_vec : '0;
   assign m_sready    = (w_busy & bus_sready) ? w_owner_vec : '0;
   assign m_svalid    = (w_busy & bus_svalid) ? w_owner_vec : '0;

   assign busy        = w_busy;
   assign owner       = r_owner;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with TIMEOUT = 8.
module tb_bus_arbiter;

   logic       clk;
   logic       rstn;
   logic [1:0] m_req;
   logic [1:0] m_grant;
   logic [1:0] m_mode;
   logic [1:0] m_wr_bus;
   logic [1:0] m_mvalid;
   logic [1:0] m_mready;
   logic [1:0] m_rd_bus;
   logic [1:0] m_sready;
   logic [1:0] m_svalid;
   logic       bus_mode;
   logic       bus_wr;
   logic       bus_mvalid;
   logic       bus_mready;
   logic       bus_rd;
   logic       bus_sready;
   logic       bus_svalid;
   logic       busy;
   logic       owner;
   logic       timeout_err;

   int n_chk = 0;
   int n_err = 0;

   bus_arbiter #(
      .TIMEOUT (8)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .m_req       (m_req),
      .m_grant     (m_grant),
      .m_mode      (m_mode),
      .m_wr_bus    (m_wr_bus),
      .m_mvalid    (m_mvalid),
      .m_mready    (m_mready),
      .m_rd_bus    (m_rd_bus),
      .m_sready    (m_sready),
      .m_svalid    (m_svalid),
      .bus_mode    (bus_mode),
      .bus_wr      (bus_wr),
      .bus_mvalid  (bus_mvalid),
      .bus_mready  (bus_mready),
      .bus_rd      (bus_rd),
      .bus_sready  (bus_sready),
      .bus_svalid  (bus_svalid),
      .busy        (busy),
      .owner       (owner),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rstn       = 1'b0;
      m_req      = 2'b01;
      m_mode     = 2'b00;
      m_wr_bus   = 2'b00;
      m_mvalid   = 2'b00;
      m_mready   = 2'b00;
      bus_rd     = 1'b0;
      bus_sready = 1'b0;
      bus_svalid = 1'b0;

      // Reset state
      #23;
      chk("rst_grant", 8'(m_grant), 8'h0);
      chk("rst_busy", 8'(busy), 8'h0);
      chk("rst_owner", 8'(owner), 8'h1);
      chk("rst_terr", 8'(timeout_err), 8'h0);

      // Release with m_req=01 held: no grant after first edge, grant after second
      rstn = 1'b1;
      cyc(1);
      chk("arm_gap", 8'(m_grant), 8'h0);
      cyc(1);
      chk("single_grant", 8'(m_grant), 8'h1);
      chk("single_busy", 8'(busy), 8'h1);
      chk("single_owner", 8'(owner), 8'h0);
      cyc(3);
      m_req = 2'b00;
      #1;
      chk("drop_same_cyc", 8'(m_grant), 8'h1);
      cyc(1);
      chk("turn_grant", 8'(m_grant), 8'h0);
      chk("turn_busy", 8'(busy), 8'h0);
      chk("turn_terr", 8'(timeout_err), 8'h0);
      chk("turn_owner", 8'(owner), 8'h0);
      cyc(1);
      chk("idle_grant", 8'(m_grant), 8'h0);

      // Tie after reset: master 0 first, master 1 three cycles after release
      rstn = 1'b0;
      #1;
      chk("rst2_owner", 8'(owner), 8'h1);
      rstn  = 1'b1;
      m_req = 2'b11;
      cyc(1);
      chk("tie_arm", 8'(m_grant), 8'h0);
      cyc(1);
      chk("tie_grant0", 8'(m_grant), 8'h1);
      chk("tie_owner0", 8'(owner), 8'h0);
      cyc(1);
      m_req = 2'b10;
      cyc(1);
      chk("hand_turn", 8'(m_grant), 8'h0);
      cyc(1);
      chk("hand_idle", 8'(m_grant), 8'h0);
      chk("hand_idle_own", 8'(owner), 8'h0);
      cyc(1);
      chk("hand_grant1", 8'(m_grant), 8'h2);
      chk("hand_owner1", 8'(owner), 8'h1);

      // Passthrough with master 1 as owner; master 0 inputs must be ignored
      bus_rd     = 1'b1;
      bus_sready = 1'b1;
      bus_svalid = 1'b0;
      m_wr_bus   = 2'b10;
      m_mode     = 2'b01;
      m_mvalid   = 2'b10;
      m_mready   = 2'b01;
      #1;
      chk("pt_sready", 8'(m_sready), 8'h2);
      chk("pt_rd", 8'(m_rd_bus), 8'h2);
      chk("pt_svalid", 8'(m_svalid), 8'h0);
      chk("pt_bus_wr", 8'(bus_wr), 8'h1);
      chk("pt_bus_mode", 8'(bus_mode), 8'h0);
      chk("pt_bus_mvalid", 8'(bus_mvalid), 8'h1);
      chk("pt_bus_mready", 8'(bus_mready), 8'h0);
      m_wr_bus = 2'b01;
      #1;
      chk("pt_bus_wr_lo", 8'(bus_wr), 8'h0);
      m_req = 2'b11;
      cyc(1);
      chk("nonowner_req", 8'(m_grant), 8'h2);
      m_req    = 2'b00;
      m_wr_bus = 2'b11;
      cyc(1);
      chk("out_grant", 8'(m_grant), 8'h0);
      chk("out_rd", 8'(m_rd_bus), 8'h0);
      chk("out_sready", 8'(m_sready), 8'h0);
      chk("out_bus_wr", 8'(bus_wr), 8'h0);
      bus_rd     = 1'b0;
      bus_sready = 1'b0;
      m_wr_bus   = 2'b00;
      m_mode     = 2'b00;
      m_mvalid   = 2'b00;
      m_mready   = 2'b00;
      cyc(1);

      // Timeout: master 0 holds for 8 BUSY cycles, master 1 pending
      m_req = 2'b01;
      cyc(1);
      chk("to_grant_b1", 8'(m_grant), 8'h1);
      m_req = 2'b11;
      cyc(6);
      chk("to_grant_b7", 8'(m_grant), 8'h1);
      cyc(1);
      chk("to_grant_b8", 8'(m_grant), 8'h1);
      chk("to_terr_b8", 8'(timeout_err), 8'h0);
      cyc(1);
      chk("to_turn_grant", 8'(m_grant), 8'h0);
      chk("to_terr_turn", 8'(timeout_err), 8'h1);
      cyc(1);
      chk("to_terr_idle", 8'(timeout_err), 8'h0);
      chk("to_idle_grant", 8'(m_grant), 8'h0);
      cyc(1);
      chk("to_next_grant", 8'(m_grant), 8'h2);
      chk("to_next_owner", 8'(owner), 8'h1);

      // Drop and expiry in the same cycle: TURN without error pulse
      cyc(7);
      chk("sim_grant_b8", 8'(m_grant), 8'h2);
      m_req = 2'b01;
      cyc(1);
      chk("sim_turn_grant", 8'(m_grant), 8'h0);
      chk("sim_terr", 8'(timeout_err), 8'h0);
      cyc(2);
      chk("sim_next_grant", 8'(m_grant), 8'h1);

      // Asynchronous reset in the middle of a BUSY cycle
      m_mvalid = 2'b01;
      #1;
      chk("mid_mvalid", 8'(bus_mvalid), 8'h1);
      #1;
      rstn = 1'b0;
      #1;
      chk("mid_rst_grant", 8'(m_grant), 8'h0);
      chk("mid_rst_mvalid", 8'(bus_mvalid), 8'h0);
      chk("mid_rst_busy", 8'(busy), 8'h0);
      rstn = 1'b1;
      #1;
      chk("mid_rst_owner", 8'(owner), 8'h1);
      cyc(1);
      chk("mid_arm_gap", 8'(m_grant), 8'h0);
      cyc(1);
      chk("mid_regrant", 8'(m_grant), 8'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
